multicycle_control: RTL

- Multicycle MIPS control unit; successor to the single-cycle main decoder.
- Moore FSM sequences each instruction over 3–5 cycles (plus memory wait states).
- Drives datapath mux selects and write enables for a shared instruction/data memory with a ready handshake.
- Sits between the instruction register opcode field and the multicycle datapath.

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/multicycle_out_decode.sv | 75 +++++++
 rtl/multicycle_control.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and the datapath control word for the
// multicycle MIPS control unit.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        ILLEGAL = 4'd12
    } state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       branchNe;
        logic       iorD;
        logic       irWrite;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
        logic       instrDone;
        logic       illegalOp;
    } ctrl_word_t;

    function automatic logic isMemOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_out_decode.sv
// Moore output decode: maps the current state (plus the memory-ready
// qualifier and, for branches, the opcode) to the datapath control word.
module multicycle_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       memReady,
    input  logic [5:0] Op,
    output ctrl_word_t ctrl
);

    always_comb begin
        // NOTE: assigning the whole word first keeps every field defined on every path, so no latches are inferred.
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.irWrite = memReady;
                ctrl.pcWrite = memReady;
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMMSH;
            end
            MEMADR, ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.iorD = 1'b1;
            end
            MEMWB: begin
                ctrl.memToReg  = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            MEMWR: begin
                // The write request stays asserted while memory stalls.
                ctrl.iorD      = 1'b1;
                ctrl.memWrite  = 1'b1;
                ctrl.instrDone = memReady;
            end
            EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.regDst    = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcSrc       = PCSRC_ALUOUT;
                ctrl.pcWriteCond = 1'b1;
                ctrl.branchNe    = (Op == OP_BNE);
                ctrl.instrDone   = 1'b1;
            end
            ADDIWB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            JUMP: begin
                ctrl.pcSrc     = PCSRC_JUMP;
                ctrl.pcWrite   = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            ILLEGAL: begin
                ctrl.illegalOp = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: state register and next-state logic, with the
// Moore output decode in a sub-module and all outputs cleared while in reset.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit BNE_EN          = 1'b1,
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       branchNe,
    output logic       iorD,
    output logic       irWrite,
    output logic       memWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSrc,
    output logic       instrDone,
    output logic       illegalOp,
    output logic [3:0] state
);

    state_t     stateQ;
    state_t     nextState;
    logic       ready;
    ctrl_word_t ctrl;
    ctrl_word_t ctrlOut;

    assign ready = MEM_HANDSHAKE ? memReady : 1'b1;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= FETCH;
        end else begin
            stateQ <= nextState;
        end
    end

    always_comb begin
        nextState = stateQ;
        case (stateQ)
            FETCH: begin
                if (ready) nextState = DECODE;
            end
            DECODE: begin
                case (Op)
                    OP_RTYPE:     nextState = EXEC;
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_BEQ:       nextState = BRANCH;
                    OP_BNE: begin
                        if (BNE_EN) nextState = BRANCH;
                        else        nextState = ILLEGAL;
                    end
                    OP_ADDI:      nextState = ADDIEX;
                    OP_J:         nextState = JUMP;
                    default:      nextState = ILLEGAL;
                endcase
            end
            MEMADR: begin
                if (Op == OP_LW) nextState = MEMRD;
                else             nextState = MEMWR;
            end
            MEMRD: begin
                if (ready) nextState = MEMWB;
            end
            MEMWR: begin
                if (ready) nextState = FETCH;
            end
            EXEC:   nextState = ALUWB;
            ADDIEX: nextState = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
                nextState = FETCH;
            end
            ILLEGAL: begin
                if (!HALT_ON_ILLEGAL) nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase
    end

    multicycle_out_decode uOutDecode (
        .state    (stateQ),
        .memReady (ready),
        .Op       (Op),
        .ctrl     (ctrl)
    );

    // Reset overrides the decode combinationally so an abandoned write never reaches memory.
    assign ctrlOut = rst_n ? ctrl : '0;
    assign state   = rst_n ? stateQ : FETCH;

    assign pcWrite     = ctrlOut.pcWrite;
    assign pcWriteCond = ctrlOut.pcWriteCond;
    assign branchNe    = ctrlOut.branchNe;
    assign iorD        = ctrlOut.iorD;
    assign irWrite     = ctrlOut.irWrite;
    assign memWrite    = ctrlOut.memWrite;
    assign memToReg    = ctrlOut.memToReg;
    assign regDst      = ctrlOut.regDst;
    assign regWrite    = ctrlOut.regWrite;
    assign aluSrcA     = ctrlOut.aluSrcA;
    assign aluSrcB     = ctrlOut.aluSrcB;
    assign aluOp       = ctrlOut.aluOp;
    assign pcSrc       = ctrlOut.pcSrc;
    assign instrDone   = ctrlOut.instrDone;
    assign illegalOp   = ctrlOut.illegalOp;

endmodule
